// File: rtl/acc_mem_arbiter_if.sv
// rtl/acc_mem_arbiter_if.sv - accelerator request and data-memory port bundle for acc_mem_arbiter
`timescale 1ns/1ps
interface acc_mem_arbiter_if #(
    parameter int NUM_ACC         = 4,
    parameter int ADDR_SIZE       = 16,
    parameter int READ_DATA_SIZE  = 512,
    parameter int WRITE_DATA_SIZE = 32
);
    logic [NUM_ACC-1:0]                 acc_read_en;
    logic [NUM_ACC*ADDR_SIZE-1:0]       acc_read_addr;
    logic [NUM_ACC-1:0]                 acc_write_en;
    logic [NUM_ACC*ADDR_SIZE-1:0]       acc_write_addr;
    logic [NUM_ACC*WRITE_DATA_SIZE-1:0] acc_write_data;
    logic [READ_DATA_SIZE-1:0]          acc_read_data;
    logic [NUM_ACC-1:0]                 acc_read_data_valid;
    logic [NUM_ACC-1:0]                 acc_write_done;
    logic                               cpu_mem_req;
    logic                               mem_en;
    logic                               mem_wr;
    logic [ADDR_SIZE-1:0]               mem_addr;
    logic [WRITE_DATA_SIZE-1:0]         mem_wdata;
    logic [READ_DATA_SIZE-1:0]          mem_rdata;

    // slave: the arbiter; master: accelerators, CPU and memory around it
    modport slave (
        input  acc_read_en, acc_read_addr, acc_write_en, acc_write_addr, acc_write_data,
        input  cpu_mem_req, mem_rdata,
        output acc_read_data, acc_read_data_valid, acc_write_done,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );
    modport master (
        output acc_read_en, acc_read_addr, acc_write_en, acc_write_addr, acc_write_data,
        output cpu_mem_req, mem_rdata,
        input  acc_read_data, acc_read_data_valid, acc_write_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - round-robin arbiter of accelerator reads/writes onto one data-memory port
`timescale 1ns/1ps
module acc_mem_arbiter #(
    parameter int NUM_ACC          = 4,
    parameter int ADDR_SIZE        = 16,
    parameter int READ_DATA_SIZE   = 512,
    parameter int WRITE_DATA_SIZE  = 32,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_mem_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam int CNT_W = $clog2(MEM_READ_LATENCY) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACC - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_READ_LATENCY - 1);

    typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t                     r_state, w_state_nxt;
    logic [IDX_W-1:0]           r_last_grant;
    logic [IDX_W-1:0]           r_gidx;
    logic                       r_op_wr;
    logic [ADDR_SIZE-1:0]       r_addr;
    logic [WRITE_DATA_SIZE-1:0] r_wdata;
    logic [CNT_W-1:0]           r_cnt;
    logic [READ_DATA_SIZE-1:0]  r_rdata;

    logic [NUM_ACC-1:0]         w_elig;
    logic [NUM_ACC-1:0]         w_gvec;
    logic [IDX_W-1:0]           w_pick;
    logic                       w_any;
    int                         w_scan;

    assign w_elig             = bus.acc_read_en | bus.acc_write_en;
    assign w_gvec             = {{(NUM_ACC-1){1'b0}}, 1'b1} << r_gidx;
    assign bus.acc_read_data  = r_rdata;

    // First eligible slot after the last grant, wrapping around
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last_grant;
        w_scan = 0;
        for (int k = 1; k <= NUM_ACC; k++) begin
            w_scan = int'(r_last_grant) + k;
            if (w_scan >= NUM_ACC) w_scan = w_scan - NUM_ACC;
            if (!w_any && w_elig[IDX_W'(w_scan)]) begin
                w_any  = 1'b1;
                w_pick = IDX_W'(w_scan);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ARB;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt             = r_state;
        bus.mem_en              = 1'b0;
        bus.mem_wr              = 1'b0;
        bus.mem_addr            = '0;
        bus.mem_wdata           = '0;
        bus.acc_read_data_valid = '0;
        bus.acc_write_done      = '0;
        case (r_state)
            ST_ARB: begin
                if (w_any) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!bus.cpu_mem_req) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_wr    = r_op_wr;
                    bus.mem_addr  = r_addr;
                    bus.mem_wdata = r_wdata;
                    w_state_nxt   = r_op_wr ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (r_op_wr) bus.acc_write_done      = w_gvec;
                else         bus.acc_read_data_valid = w_gvec;
                w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    // A slot with both lines up is granted its read; the write stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= LAST_IDX;
            r_gidx       <= '0;
            r_op_wr      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_any) begin
                        r_gidx       <= w_pick;
                        r_last_grant <= w_pick;
                        r_op_wr      <= !bus.acc_read_en[w_pick];
                        if (bus.acc_read_en[w_pick]) begin
                            r_addr  <= bus.acc_read_addr[w_pick*ADDR_SIZE +: ADDR_SIZE];
                            r_wdata <= '0;
                        end else begin
                            r_addr  <= bus.acc_write_addr[w_pick*ADDR_SIZE +: ADDR_SIZE];
                            r_wdata <= bus.acc_write_data[w_pick*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!bus.cpu_mem_req && !r_op_wr) r_cnt <= CNT_LOAD;
                end
                ST_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    else             r_rdata <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb/tb_acc_mem_arbiter.sv - self-checking bench for acc_mem_arbiter at read latencies 1 and 3
`timescale 1ns/1ps
module tb_acc_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int RW = 512;
    localparam int WW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    acc_mem_arbiter_if #(.NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW), .WRITE_DATA_SIZE(WW)) bus1();
    acc_mem_arbiter_if #(.NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW), .WRITE_DATA_SIZE(WW)) bus3();

    acc_mem_arbiter #(.NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW), .WRITE_DATA_SIZE(WW),
                      .MEM_READ_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    acc_mem_arbiter #(.NUM_ACC(N), .ADDR_SIZE(AW), .READ_DATA_SIZE(RW), .WRITE_DATA_SIZE(WW),
                      .MEM_READ_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    typedef struct {
        int            slot;
        logic          wr;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } op_t;

    typedef struct {
        int            slot;
        logic          wr;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        int            exp_issue;
        int            exp_pulse;
        logic [N-1:0]  exp_vec;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] pat(input logic [AW-1:0] a);
        logic [RW-1:0] p;
        for (int i = 0; i < RW/32; i++) p[i*32 +: 32] = {a, 16'(i) ^ 16'hC35A};
        return p;
    endfunction

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory models: read data is valid only MEM_READ_LATENCY cycles after the issue cycle
    logic [AW:0] m1 = '0;
    logic [AW:0] m3 [3] = '{default: '0};
    always @(posedge clk) begin
        m1    <= {bus1.mem_en && !bus1.mem_wr, bus1.mem_addr};
        m3[0] <= {bus3.mem_en && !bus3.mem_wr, bus3.mem_addr};
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign bus1.mem_rdata = m1[AW]    ? pat(m1[AW-1:0])    : '0;
    assign bus3.mem_rdata = m3[2][AW] ? pat(m3[2][AW-1:0]) : '0;

    // Requester agent for dut1: per-slot read and write lanes, head held until its pulse
    op_t rq[N][$];
    op_t wq[N][$];
    op_t sb[$];
    logic [N-1:0]      seen_v = '0, seen_d = '0;
    logic [N-1:0]      a_re, a_we;
    logic [N*AW-1:0]   a_ra, a_wa;
    logic [N*WW-1:0]   a_wd;

    initial begin
        bus1.acc_read_en = '0; bus1.acc_read_addr = '0; bus1.acc_write_en = '0;
        bus1.acc_write_addr = '0; bus1.acc_write_data = '0; bus1.cpu_mem_req = 1'b0;
        bus3.acc_read_en = '0; bus3.acc_read_addr = '0; bus3.acc_write_en = '0;
        bus3.acc_write_addr = '0; bus3.acc_write_data = '0; bus3.cpu_mem_req = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (seen_v[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                if (seen_d[i] && wq[i].size() != 0) void'(wq[i].pop_front());
            end
            seen_v = '0; seen_d = '0;
            a_re = '0; a_we = '0; a_ra = '0; a_wa = '0; a_wd = '0;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() != 0) begin a_re[i] = 1'b1; a_ra[i*AW +: AW] = rq[i][0].addr; end
                if (wq[i].size() != 0) begin
                    a_we[i] = 1'b1; a_wa[i*AW +: AW] = wq[i][0].addr; a_wd[i*WW +: WW] = wq[i][0].data;
                end
            end
            bus1.acc_read_en = a_re; bus1.acc_read_addr = a_ra;
            bus1.acc_write_en = a_we; bus1.acc_write_addr = a_wa; bus1.acc_write_data = a_wd;
        end
    end

    // dut1 monitor and scoreboard
    int            last_issue_cyc = 0, last_pulse_cyc = 0, issue_cnt = 0, pulse_cnt = 0;
    logic [AW-1:0] li_addr = '0;
    logic [WW-1:0] li_data = '0;
    logic [N-1:0]  last_pulse_vec = '0;
    logic [N-1:0]  mv, md;
    op_t           e;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            mv = bus1.acc_read_data_valid;
            md = bus1.acc_write_done;
            if (!bus1.mem_en) check("idle_bus_zero", {bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata}, '0);
            else begin
                issue_cnt++; last_issue_cyc = cyc; li_addr = bus1.mem_addr; li_data = bus1.mem_wdata;
            end
            if ((mv | md) != '0) begin
                check("pulse_onehot", $onehot(mv | md), 1);
                last_pulse_cyc = cyc; last_pulse_vec = mv | md; pulse_cnt++;
                seen_v = seen_v | mv; seen_d = seen_d | md;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got pulse %b expected none", mv | md);
                end else begin
                    e = sb.pop_front();
                    check("sb_vec", mv | md, 4'b0001 << e.slot);
                    check("sb_op", md != '0, e.wr);
                    check("sb_addr", li_addr, e.addr);
                    if (e.wr) check("sb_wdata", li_data, e.data);
                    else      check("sb_rdata", bus1.acc_read_data, pat(e.addr));
                    check("sb_lat", cyc - last_issue_cyc, e.wr ? 1 : 2);
                end
            end
        end
    end

    // dut3 monitor
    int            i3_cyc = 0, p3_cnt = 0, p3_cyc = 0;
    logic [N-1:0]  p3_vec = '0;
    logic [RW-1:0] p3_rdata = '0;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus3.mem_en) i3_cyc = cyc;
            if ((bus3.acc_read_data_valid | bus3.acc_write_done) != '0) begin
                p3_cnt++; p3_cyc = cyc; p3_rdata = bus3.acc_read_data;
                p3_vec = bus3.acc_read_data_valid | bus3.acc_write_done;
            end
        end
    end

    function automatic bit lanes_busy();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0 || wq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_lane(input op_t o);
        if (o.wr) wq[o.slot].push_back(o);
        else      rq[o.slot].push_back(o);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb.size() != 0 || lanes_busy()) && n < budget) begin
            @(posedge clk); #3; n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_done: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
    endtask

    task automatic wait_p3(input int start, input int budget);
        int n = 0;
        while (p3_cnt == start && n < budget) begin @(negedge clk); #1; n++; end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_p3: got no pulse expected one");
        end
    endtask

    vec_t tv[6];
    op_t  o;
    int   req_cyc, base_issue, base_pulse, p0, c;

    initial begin
        tv[0] = '{2, 1'b1, 16'h5000, 32'h0000_0005, 1, 2, 4'b0100};
        tv[1] = '{0, 1'b0, 16'h1000, 32'h0,         1, 3, 4'b0001};
        tv[2] = '{3, 1'b1, 16'hFFFF, 32'hDEAD_BEEF, 1, 2, 4'b1000};
        tv[3] = '{1, 1'b0, 16'h0000, 32'h0,         1, 3, 4'b0010};
        tv[4] = '{3, 1'b0, 16'hABCD, 32'h0,         1, 3, 4'b1000};
        tv[5] = '{0, 1'b1, 16'h0001, 32'hFFFF_FFFF, 1, 2, 4'b0001};

        repeat (3) @(negedge clk);
        check("rst_mem_en", {bus1.mem_en, bus3.mem_en}, '0);
        check("rst_mem_bus", {bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata}, '0);
        check("rst_pulses", {bus1.acc_read_data_valid, bus1.acc_write_done,
                             bus3.acc_read_data_valid, bus3.acc_write_done}, '0);
        check("rst_rdata", bus1.acc_read_data | bus3.acc_read_data, '0);
        @(posedge clk); #2; rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            o = '{tv[i].slot, tv[i].wr, tv[i].addr, tv[i].data};
            @(posedge clk); #2;
            add_lane(o); sb.push_back(o); req_cyc = cyc + 1;
            wait_done(40);
            check($sformatf("tv%0d_issue", i), last_issue_cyc - req_cyc, tv[i].exp_issue);
            check($sformatf("tv%0d_pulse", i), last_pulse_cyc - req_cyc, tv[i].exp_pulse);
            check($sformatf("tv%0d_vec", i), last_pulse_vec, tv[i].exp_vec);
        end

        // CPU stalls: {op, stall start offset, length, expected issue and pulse offsets}
        for (int s = 0; s < 2; s++) begin
            o = (s == 0) ? '{1, 1'b1, 16'h2222, 32'h1234_5678} : '{2, 1'b0, 16'h3333, 32'h0};
            @(posedge clk); #2;
            add_lane(o); sb.push_back(o); req_cyc = cyc + 1; base_issue = issue_cnt;
            repeat ((s == 0) ? 2 : 1) begin @(posedge clk); #2; end
            bus1.cpu_mem_req = 1'b1;
            repeat ((s == 0) ? 5 : 3) begin @(posedge clk); #2; end
            bus1.cpu_mem_req = 1'b0;
            wait_done(40);
            check($sformatf("stall%0d_issue", s), last_issue_cyc - req_cyc, (s == 0) ? 6 : 3);
            check($sformatf("stall%0d_pulse", s), last_pulse_cyc - req_cyc, (s == 0) ? 7 : 5);
            check($sformatf("stall%0d_issues", s), issue_cnt - base_issue, 1);
        end

        // All four slots writing continuously from reset: grants 0,1,2,3,0,...
        do_reset();
        base_pulse = pulse_cnt;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < N; s++) begin
                o = '{s, 1'b1, 16'(16'h6000 + s*16 + k), $urandom};
                add_lane(o); sb.push_back(o);
            end
        wait_done(200);
        check("rr4_count", pulse_cnt - base_pulse, 12);

        // Slots 1 and 3, eight back-to-back writes each, must alternate
        do_reset();
        base_pulse = pulse_cnt;
        for (int k = 0; k < 8; k++) begin
            o = '{1, 1'b1, 16'(16'h5008 + 32*k), $urandom}; add_lane(o); sb.push_back(o);
            o = '{3, 1'b1, 16'(16'h5408 + 32*k), $urandom}; add_lane(o); sb.push_back(o);
        end
        wait_done(300);
        check("alt_count", pulse_cnt - base_pulse, 16);

        // Slot 2 with read and write both pending: read first, write on a later grant
        do_reset();
        o = '{0, 1'b1, 16'h7000, 32'hA0A0_A0A0}; add_lane(o); sb.push_back(o);
        o = '{2, 1'b0, 16'h7200, 32'h0};         add_lane(o); sb.push_back(o);
        o = '{2, 1'b1, 16'h7204, 32'hC2C2_C2C2}; add_lane(o); sb.push_back(o);
        wait_done(60);

        // dut3 (latency 3): single read on slot 0
        @(posedge clk); #2;
        p0 = p3_cnt; c = cyc;
        bus3.acc_read_addr[0 +: AW] = 16'h1000; bus3.acc_read_en = 4'b0001;
        wait_p3(p0, 30);
        @(posedge clk); #1; bus3.acc_read_en = '0;
        check("l3_issue", i3_cyc - c, 1);
        check("l3_pulse", p3_cyc - c, 5);
        check("l3_vec", p3_vec, 4'b0001);
        check("l3_rdata", p3_rdata, pat(16'h1000));

        // dut3: reset during WAIT of a slot 1 read
        @(posedge clk); #2;
        p0 = p3_cnt; c = cyc;
        bus3.acc_read_addr[AW +: AW] = 16'h2000; bus3.acc_read_en = 4'b0010;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        check("rstw_issue", i3_cyc - c, 1);
        check("rstw_rdata", bus3.acc_read_data, '0);
        check("rstw_outs", {bus3.mem_en, bus3.mem_wr, bus3.mem_addr, bus3.acc_read_data_valid,
                            bus3.acc_write_done}, '0);
        bus3.acc_read_en = '0;
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1;
        repeat (8) @(posedge clk);
        check("rstw_no_pulse", p3_cnt - p0, 0);

        // After reset slot 0 outranks slot 2
        @(posedge clk); #2;
        p0 = p3_cnt;
        bus3.acc_read_addr[0 +: AW] = 16'h3000; bus3.acc_read_addr[2*AW +: AW] = 16'h3200;
        bus3.acc_read_en = 4'b0101;
        wait_p3(p0, 30);
        @(posedge clk); #1; bus3.acc_read_en = 4'b0100;
        check("post_rst_first", p3_vec, 4'b0001);
        check("post_rst_rdata0", p3_rdata, pat(16'h3000));
        wait_p3(p0 + 1, 30);
        @(posedge clk); #1; bus3.acc_read_en = '0;
        check("post_rst_second", p3_vec, 4'b0100);
        check("post_rst_rdata2", p3_rdata, pat(16'h3200));

        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
